gaussian_frame_driver: RTL and testbench

Bus initiator that drives the 3x3 Gaussian accelerator over its register interface. It fetches each 3x3 window of a frame from pixel memory, loads the nine tap registers, reads the filtered result and writes it to result memory. The block sits between the HPS-facing CSR bus and the accelerator, removing the 10 CPU bus transactions per output pixel.

---
 rtl/gaussian_frame_driver_pkg.sv | 39 +++
 rtl/gaussian_frame_driver_if.sv | 38 +++
 rtl/gaussian_frame_driver_win_addr_gen.sv | 87 ++++++++
 rtl/gaussian_frame_driver.sv | 193 +++++++++++++++++++
 tb/tb_gaussian_frame_driver.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gaussian_frame_driver_pkg.sv
// rtl/gaussian_frame_driver_pkg.sv - shared constants and types for the Gaussian frame driver
package gaussian_pkg;

   // CSR word offsets
   localparam logic [2:0] CSR_CTRL      = 3'd0;
   localparam logic [2:0] CSR_SRC_BASE  = 3'd1;
   localparam logic [2:0] CSR_DST_BASE  = 3'd2;
   localparam logic [2:0] CSR_WIDTH     = 3'd3;
   localparam logic [2:0] CSR_HEIGHT    = 3'd4;
   localparam logic [2:0] CSR_OUT_COUNT = 3'd5;

   // accelerator register map: result at 0, taps row-major at 1..9
   localparam logic [3:0] ACC_RESULT = 4'd0;
   localparam logic [3:0] ACC_TAP0   = 4'd1;
   localparam logic [3:0] ACC_TAP1   = 4'd2;
   localparam logic [3:0] ACC_TAP2   = 4'd3;
   localparam logic [3:0] ACC_TAP3   = 4'd4;
   localparam logic [3:0] ACC_TAP4   = 4'd5;
   localparam logic [3:0] ACC_TAP5   = 4'd6;
   localparam logic [3:0] ACC_TAP6   = 4'd7;
   localparam logic [3:0] ACC_TAP7   = 4'd8;
   localparam logic [3:0] ACC_TAP8   = 4'd9;

   // index of the last tap fetched from pixel memory in a window
   localparam logic [3:0] LAST_TAP = 4'd8;

   // bus cycles spent on each output pixel
   localparam int CYCLES_PER_OUT = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD_LAST,
      ST_RESULT,
      ST_STORE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/gaussian_frame_driver_if.sv
// rtl/gaussian_frame_driver_if.sv - CSR, pixel/result memory and accelerator bus bundle
interface gaussian_frame_driver_if #(
   parameter int ADDR_W = 16
);
   logic [2:0]        csr_addr;
   logic              csr_rd_en;
   logic              csr_wr_en;
   logic [31:0]       csr_writedata;
   logic [31:0]       csr_readdata;

   logic [ADDR_W-1:0] pix_addr;
   logic              pix_rd_en;
   logic [31:0]       pix_rddata;

   logic [ADDR_W-1:0] res_addr;
   logic              res_wr_en;
   logic [31:0]       res_wrdata;

   logic [3:0]        acc_addr;
   logic              acc_rd_en;
   logic              acc_wr_en;
   logic [31:0]       acc_writedata;
   logic [31:0]       acc_readdata;

   // frame driver side
   modport master (
      input  csr_addr, csr_rd_en, csr_wr_en, csr_writedata, pix_rddata, acc_readdata,
      output csr_readdata, pix_addr, pix_rd_en, res_addr, res_wr_en, res_wrdata,
      output acc_addr, acc_rd_en, acc_wr_en, acc_writedata
   );

   // CPU, memories and accelerator side
   modport slave (
      output csr_addr, csr_rd_en, csr_wr_en, csr_writedata, pix_rddata, acc_readdata,
      input  csr_readdata, pix_addr, pix_rd_en, res_addr, res_wr_en, res_wrdata,
      input  acc_addr, acc_rd_en, acc_wr_en, acc_writedata
   );
endinterface

// File: rtl/gaussian_frame_driver_win_addr_gen.sv
// rtl/gaussian_frame_driver_win_addr_gen.sv - window walker producing tap and destination addresses
module gaussian_win_addr_gen
   import gaussian_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   input  logic [3:0]        tap_idx,
   output logic [ADDR_W-1:0] tap_addr,
   output logic [ADDR_W-1:0] dst_addr,
   output logic              last_win
);

   logic [ADDR_W-1:0] width_a;
   logic [ADDR_W-1:0] row_addr;
   logic [ADDR_W-1:0] win_addr;
   logic [ADDR_W-1:0] dst_q;
   logic [DIM_W-1:0]  col;
   logic [DIM_W-1:0]  row;
   logic [DIM_W-1:0]  col_last;
   logic [DIM_W-1:0]  row_last;
   logic [ADDR_W-1:0] row_off;
   logic [ADDR_W-1:0] col_off;

   // latch frame geometry on load, then walk windows in raster order one step at a time
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         width_a  <= '0;
         row_addr <= '0;
         win_addr <= '0;
         dst_q    <= '0;
         col      <= '0;
         row      <= '0;
         col_last <= '0;
         row_last <= '0;
      end else if (load) begin
         width_a  <= ADDR_W'(width);
         col_last <= width - DIM_W'(3);
         row_last <= height - DIM_W'(3);
         row_addr <= src_base;
         win_addr <= src_base;
         dst_q    <= dst_base;
         col      <= '0;
         row      <= '0;
      end else if (step) begin
         dst_q <= dst_q + ADDR_W'(1);
         if (col == col_last) begin
            col      <= '0;
            row      <= row + DIM_W'(1);
            row_addr <= row_addr + width_a;
            win_addr <= row_addr + width_a;
         end else begin
            col      <= col + DIM_W'(1);
            win_addr <= win_addr + ADDR_W'(1);
         end
      end
   end

   // tap k sits at row k/3, column k%3 of the window; rows are whole image widths apart
   always_comb begin
      row_off = '0;
      col_off = '0;
      case (tap_idx)
         4'd0, 4'd1, 4'd2: row_off = '0;
         4'd3, 4'd4, 4'd5: row_off = width_a;
         default:          row_off = {width_a[ADDR_W-2:0], 1'b0};
      endcase
      case (tap_idx)
         4'd1, 4'd4, 4'd7: col_off = ADDR_W'(1);
         4'd2, 4'd5, 4'd8: col_off = ADDR_W'(2);
         default:          col_off = '0;
      endcase
   end

   assign tap_addr = win_addr + row_off + col_off;
   assign dst_addr = dst_q;
   assign last_win = (col == col_last) && (row == row_last);

endmodule

// File: rtl/gaussian_frame_driver.sv
// rtl/gaussian_frame_driver.sv - drives the 3x3 Gaussian accelerator over a whole frame
module gaussian_frame_driver
   import gaussian_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 12
) (
   input  logic                   clk,
   input  logic                   reset_n,
   gaussian_frame_driver_if.master bus
);

   state_t            state;
   logic [ADDR_W-1:0] src_base;
   logic [ADDR_W-1:0] dst_base;
   logic [DIM_W-1:0]  width_q;
   logic [DIM_W-1:0]  height_q;
   logic [31:0]       out_count;
   logic              busy_q;
   logic              done_q;
   logic [3:0]        tap_k;
   logic              last_q;

   logic [ADDR_W-1:0] pix_addr_q;
   logic              pix_rd_q;
   logic [ADDR_W-1:0] res_addr_q;
   logic              res_wr_q;
   logic [31:0]       res_data_q;
   logic [3:0]        acc_addr_q;
   logic              acc_rd_q;
   logic              acc_wr_q;

   logic              start_ok;
   logic              frame_small;
   logic [3:0]        gen_tap_idx;
   logic [ADDR_W-1:0] gen_tap_addr;
   logic [ADDR_W-1:0] gen_dst_addr;
   logic              gen_last;
   logic [31:0]       rd_mux;

   assign start_ok    = bus.csr_wr_en && (bus.csr_addr == CSR_CTRL) &&
                        bus.csr_writedata[0] && !busy_q;
   assign frame_small = (width_q < DIM_W'(3)) || (height_q < DIM_W'(3));
   // in FETCH look one tap ahead; elsewhere point at tap 0 of the current window
   assign gen_tap_idx = (state == ST_FETCH) ? tap_k + 4'd1 : 4'd0;

   gaussian_win_addr_gen #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W)
   ) u_addr_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (start_ok && !frame_small),
      .step     (state == ST_LOAD_LAST),
      .src_base (src_base),
      .dst_base (dst_base),
      .width    (width_q),
      .height   (height_q),
      .tap_idx  (gen_tap_idx),
      .tap_addr (gen_tap_addr),
      .dst_addr (gen_dst_addr),
      .last_win (gen_last)
   );

   // configuration registers, frozen while a frame is in flight
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         src_base <= '0;
         dst_base <= '0;
         width_q  <= '0;
         height_q <= '0;
      end else if (bus.csr_wr_en && !busy_q) begin
         case (bus.csr_addr)
            CSR_SRC_BASE: src_base <= bus.csr_writedata[ADDR_W-1:0];
            CSR_DST_BASE: dst_base <= bus.csr_writedata[ADDR_W-1:0];
            CSR_WIDTH:    width_q  <= bus.csr_writedata[DIM_W-1:0];
            CSR_HEIGHT:   height_q <= bus.csr_writedata[DIM_W-1:0];
            default:      ;
         endcase
      end
   end

   // frame sequencer: nine pixel fetches overlapped with tap loads, then read result and store it
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         out_count  <= '0;
         tap_k      <= '0;
         last_q     <= 1'b0;
         pix_addr_q <= '0;
         pix_rd_q   <= 1'b0;
         res_addr_q <= '0;
         res_wr_q   <= 1'b0;
         res_data_q <= '0;
         acc_addr_q <= '0;
         acc_rd_q   <= 1'b0;
         acc_wr_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               state <= ST_IDLE;
               if (start_ok) begin
                  done_q    <= 1'b0;
                  out_count <= '0;
                  if (frame_small) begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state      <= ST_FETCH;
                     busy_q     <= 1'b1;
                     tap_k      <= '0;
                     pix_rd_q   <= 1'b1;
                     pix_addr_q <= src_base;
                  end
               end
            end
            ST_FETCH: begin
               // the pixel read in this cycle is loaded as tap k during the next one
               acc_wr_q <= 1'b1;
               if (tap_k == LAST_TAP) begin
                  state      <= ST_LOAD_LAST;
                  pix_rd_q   <= 1'b0;
                  acc_addr_q <= ACC_TAP8;
               end else begin
                  tap_k      <= tap_k + 4'd1;
                  pix_addr_q <= gen_tap_addr;
                  acc_addr_q <= ACC_TAP0 + tap_k;
               end
            end
            ST_LOAD_LAST: begin
               // the walker steps at this edge, so grab this window's destination and last flag first
               state      <= ST_RESULT;
               acc_wr_q   <= 1'b0;
               acc_rd_q   <= 1'b1;
               acc_addr_q <= ACC_RESULT;
               res_addr_q <= gen_dst_addr;
               last_q     <= gen_last;
            end
            ST_RESULT: begin
               state      <= ST_STORE;
               acc_rd_q   <= 1'b0;
               res_wr_q   <= 1'b1;
               res_data_q <= bus.acc_readdata;
            end
            ST_STORE: begin
               res_wr_q  <= 1'b0;
               out_count <= out_count + 32'd1;
               if (last_q) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  state      <= ST_FETCH;
                  tap_k      <= '0;
                  pix_rd_q   <= 1'b1;
                  pix_addr_q <= gen_tap_addr;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // CSR read mux, quiet when not being read
   always_comb begin
      rd_mux = '0;
      if (bus.csr_rd_en) begin
         case (bus.csr_addr)
            CSR_CTRL:      rd_mux = {30'd0, done_q, busy_q};
            CSR_SRC_BASE:  rd_mux = 32'(src_base);
            CSR_DST_BASE:  rd_mux = 32'(dst_base);
            CSR_WIDTH:     rd_mux = 32'(width_q);
            CSR_HEIGHT:    rd_mux = 32'(height_q);
            CSR_OUT_COUNT: rd_mux = out_count;
            default:       rd_mux = '0;
         endcase
      end
   end

   assign bus.csr_readdata  = rd_mux;
   assign bus.pix_addr      = pix_addr_q;
   assign bus.pix_rd_en     = pix_rd_q;
   assign bus.res_addr      = res_addr_q;
   assign bus.res_wr_en     = res_wr_q;
   assign bus.res_wrdata    = res_data_q;
   assign bus.acc_addr      = acc_addr_q;
   assign bus.acc_rd_en     = acc_rd_q;
   assign bus.acc_wr_en     = acc_wr_q;
   assign bus.acc_writedata = acc_wr_q ? bus.pix_rddata : 32'd0;

endmodule

// File: tb/tb_gaussian_frame_driver.sv
// tb/tb_gaussian_frame_driver.sv - self-checking bench for gaussian_frame_driver
module tb_gaussian_frame_driver;

   logic clk;
   logic reset_n;
   int   cyc = 0;

   gaussian_frame_driver_if #(.ADDR_W(16)) bus ();

   gaussian_frame_driver #(
      .ADDR_W (16),
      .DIM_W  (12)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // pixel memory with one-cycle read latency
   logic [31:0] pix_mem [0:65535];
   always @(posedge clk) begin
      if (bus.pix_rd_en) bus.pix_rddata <= pix_mem[bus.pix_addr];
   end

   // accelerator model: nine tap registers and a rounded 3x3 Gaussian (weights sum to 1025/1024)
   logic [31:0] acc_tap [9];
   always @(posedge clk) begin
      if (bus.acc_wr_en && bus.acc_addr >= 4'd1 && bus.acc_addr <= 4'd9)
         acc_tap[bus.acc_addr - 4'd1] <= bus.acc_writedata;
   end

   function automatic int gauss_wt(input int i);
      if (i == 4) return 209;
      if (i % 2 == 1) return 127;
      return 77;
   endfunction

   function automatic logic [31:0] gauss(input logic [31:0] t [9]);
      logic [63:0] s;
      s = 64'd0;
      for (int i = 0; i < 9; i++) s += 64'(t[i]) * 64'(gauss_wt(i));
      return 32'((s + 64'd512) >> 10);
   endfunction

   always_comb begin
      bus.acc_readdata = 32'd0;
      if (bus.acc_rd_en && bus.acc_addr == 4'd0) bus.acc_readdata = gauss(acc_tap);
   end

   // bus monitor
   logic [47:0] res_log [$];
   logic [35:0] acc_log [$];
   int          pix_cyc_log [$];
   int          acc_rd_cnt = 0;
   int          viol_cnt = 0;
   always @(negedge clk) begin
      logic [3:0] s;
      s = {bus.res_wr_en, bus.acc_rd_en, bus.acc_wr_en, bus.pix_rd_en};
      if (bus.res_wr_en) res_log.push_back({bus.res_addr, bus.res_wrdata});
      if (bus.acc_wr_en) acc_log.push_back({bus.acc_addr, bus.acc_writedata});
      if (bus.acc_rd_en) acc_rd_cnt++;
      if (bus.pix_rd_en) pix_cyc_log.push_back(cyc);
      if (!(s == 4'b0000 || s == 4'b0001 || s == 4'b0010 || s == 4'b0100 ||
            s == 4'b1000 || s == 4'b0011)) viol_cnt++;
   end

   int n_checks = 0;
   int n_fail = 0;
   int start_cyc, snap_res, snap_acc, snap_ard, snap_pix, snap_viol;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.csr_addr = a; bus.csr_writedata = d; bus.csr_wr_en = 1'b1;
      @(negedge clk);
      bus.csr_wr_en = 1'b0;
   endtask

   task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.csr_addr = a; bus.csr_rd_en = 1'b1;
      #1 d = bus.csr_readdata;
      bus.csr_rd_en = 1'b0;
   endtask

   task automatic config_frame(input int src, input int dst, input int w, input int h);
      csr_write(3'd1, 32'(src));
      csr_write(3'd2, 32'(dst));
      csr_write(3'd3, 32'(w));
      csr_write(3'd4, 32'(h));
   endtask

   task automatic start_frame();
      @(negedge clk);
      snap_res  = res_log.size();
      snap_acc  = acc_log.size();
      snap_ard  = acc_rd_cnt;
      snap_pix  = pix_cyc_log.size();
      snap_viol = viol_cnt;
      start_cyc = cyc;
      bus.csr_addr = 3'd0; bus.csr_writedata = 32'd1; bus.csr_wr_en = 1'b1;
      @(negedge clk);
      bus.csr_wr_en = 1'b0;
   endtask

   // called at a negedge; polls CTRL every cycle, dcyc = -1 on timeout
   task automatic wait_done(output int dcyc, output logic [31:0] first_ctrl);
      logic [31:0] d;
      dcyc = -1;
      first_ctrl = 32'hdead;
      for (int i = 0; i < 2000; i++) begin
         bus.csr_addr = 3'd0; bus.csr_rd_en = 1'b1;
         #1 d = bus.csr_readdata;
         bus.csr_rd_en = 1'b0;
         if (i == 0) first_ctrl = d;
         if (d[1]) begin
            dcyc = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   function automatic logic [15:0] src_tap(input int src, input int w, input int r, input int c,
                                           input int t);
      return 16'(src + (r + t / 3) * w + c + t % 3);
   endfunction

   function automatic logic [31:0] ref_out(input int src, input int w, input int r, input int c);
      logic [31:0] t [9];
      for (int k = 0; k < 9; k++) t[k] = pix_mem[src_tap(src, w, r, c, k)];
      return gauss(t);
   endfunction

   task automatic check_frame(input string tag, input int src, input int dst, input int w,
                              input int h, input int dcyc, input logic [31:0] ctrl0);
      int n, nr, na, win;
      logic [31:0] d;
      n = (w >= 3 && h >= 3) ? (w - 2) * (h - 2) : 0;
      chk({tag, "_done_cycle"}, 64'(dcyc - start_cyc), 64'((n == 0) ? 1 : 12 * n + 1));
      chk({tag, "_busy_early"}, 64'(ctrl0[0]), 64'(n > 0));
      chk({tag, "_done_early"}, 64'(ctrl0[1]), 64'(n == 0));
      csr_read(3'd0, d);
      chk({tag, "_ctrl_end"}, 64'(d), 64'd2);
      csr_read(3'd5, d);
      chk({tag, "_out_count"}, 64'(d), 64'(n));
      nr = res_log.size() - snap_res;
      chk({tag, "_n_writes"}, 64'(nr), 64'(n));
      for (int k = 0; k < n && k < nr; k++)
         chk($sformatf("%s_write%0d", tag, k), 64'(res_log[snap_res + k]),
             64'({16'(dst + k), ref_out(src, w, k / (w - 2), k % (w - 2))}));
      na = acc_log.size() - snap_acc;
      chk({tag, "_n_tap_loads"}, 64'(na), 64'(9 * n));
      for (int k = 0; k < 9 * n && k < na; k++) begin
         win = k / 9;
         chk($sformatf("%s_tap%0d", tag, k), 64'(acc_log[snap_acc + k]),
             64'({4'(k % 9 + 1), pix_mem[src_tap(src, w, win / (w - 2), win % (w - 2), k % 9)]}));
      end
      chk({tag, "_n_acc_reads"}, 64'(acc_rd_cnt - snap_ard), 64'(n));
      chk({tag, "_n_pix_reads"}, 64'(pix_cyc_log.size() - snap_pix), 64'(9 * n));
      chk({tag, "_strobe_overlap"}, 64'(viol_cnt - snap_viol), 64'd0);
      if (pix_cyc_log.size() > snap_pix)
         chk({tag, "_first_fetch"}, 64'(pix_cyc_log[snap_pix] - start_cyc), 64'd1);
   endtask

   int          dcyc;
   logic [31:0] ctrl0, rdat;
   int          rw, rh, rsrc, rdst;

   initial begin
      reset_n = 1'b0;
      bus.csr_addr = 3'd0; bus.csr_rd_en = 1'b0; bus.csr_wr_en = 1'b0; bus.csr_writedata = 32'd0;
      for (int i = 0; i < 65536; i++) pix_mem[i] = $urandom;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_strobes", 64'({bus.pix_rd_en, bus.res_wr_en, bus.acc_rd_en, bus.acc_wr_en}), 64'd0);
      chk("rst_addrs", 64'({bus.pix_addr, bus.res_addr, bus.acc_addr}), 64'd0);
      chk("rst_data", {bus.res_wrdata, bus.acc_writedata}, 64'd0);
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         csr_read(3'(a), rdat);
         chk($sformatf("rst_csr%0d", a), 64'(rdat), 64'd0);
      end
      csr_write(3'd1, 32'h1234);
      #1 chk("rd_quiet", 64'(bus.csr_readdata), 64'd0);
      csr_write(3'd6, 32'hffff);
      csr_read(3'd6, rdat);
      chk("unmapped_rd", 64'(rdat), 64'd0);

      // 3x3 all ones
      for (int i = 0; i < 9; i++) pix_mem[i] = 32'd1;
      config_frame(0, 'h100, 3, 3);
      start_frame();
      wait_done(dcyc, ctrl0);
      chk("t1_done13", 64'(dcyc - start_cyc), 64'd13);
      chk("t1_write", 64'((res_log.size() > snap_res) ? res_log[snap_res] : 48'h0),
          64'({16'h100, 32'd1}));
      check_frame("t1", 0, 'h100, 3, 3, dcyc, ctrl0);

      // 3x3 impulse in the centre
      for (int i = 0; i < 9; i++) pix_mem['h10 + i] = (i == 4) ? 32'd1000 : 32'd0;
      config_frame('h10, 'h110, 3, 3);
      start_frame();
      wait_done(dcyc, ctrl0);
      chk("t2_data204", 64'((res_log.size() > snap_res) ? res_log[snap_res][31:0] : 32'h0), 64'd204);
      check_frame("t2", 'h10, 'h110, 3, 3, dcyc, ctrl0);

      // 4x4 flat field
      for (int i = 0; i < 16; i++) pix_mem['h20 + i] = 32'd10;
      config_frame('h20, 'h200, 4, 4);
      start_frame();
      wait_done(dcyc, ctrl0);
      chk("t3_done49", 64'(dcyc - start_cyc), 64'd49);
      check_frame("t3", 'h20, 'h200, 4, 4, dcyc, ctrl0);

      // degenerate frame: no traffic
      config_frame('h40, 'h240, 2, 5);
      start_frame();
      wait_done(dcyc, ctrl0);
      check_frame("t4", 'h40, 'h240, 2, 5, dcyc, ctrl0);

      // WIDTH write and restart during a 5x5 frame are ignored
      config_frame('h1000, 'h300, 5, 5);
      start_frame();
      repeat (25) @(negedge clk);
      csr_write(3'd3, 32'd3);
      csr_write(3'd0, 32'd1);
      wait_done(dcyc, ctrl0);
      check_frame("t5", 'h1000, 'h300, 5, 5, dcyc, ctrl0);
      csr_read(3'd3, rdat);
      chk("t5_width_kept", 64'(rdat), 64'd5);

      // reset in the middle of a 4x4 frame
      config_frame('h2000, 'h400, 4, 4);
      start_frame();
      repeat (19) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("t6_strobes", 64'({bus.pix_rd_en, bus.res_wr_en, bus.acc_rd_en, bus.acc_wr_en}), 64'd0);
      for (int a = 0; a < 6; a++) begin
         csr_read(3'(a), rdat);
         chk($sformatf("t6_csr%0d", a), 64'(rdat), 64'd0);
      end
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("t6_writes_before_reset", 64'(res_log.size() - snap_res), 64'd1);
      csr_read(3'd0, rdat);
      chk("t6_ctrl_idle", 64'(rdat), 64'd0);
      config_frame('h2000, 'h400, 4, 4);
      start_frame();
      wait_done(dcyc, ctrl0);
      check_frame("t6_rerun", 'h2000, 'h400, 4, 4, dcyc, ctrl0);

      // random geometry, including address wrap at the top of memory
      for (int it = 0; it < 4; it++) begin
         rw   = int'($urandom_range(3, 6));
         rh   = int'($urandom_range(3, 6));
         rsrc = (it == 0) ? 'hfff0 : int'($urandom_range(0, 65535));
         rdst = (it == 1) ? 'hfffe : int'($urandom_range(0, 65535));
         config_frame(rsrc, rdst, rw, rh);
         start_frame();
         wait_done(dcyc, ctrl0);
         check_frame($sformatf("rnd%0d", it), rsrc, rdst, rw, rh, dcyc, ctrl0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
